// File: rtl/store_buffer_pkg.sv
// Shared types for the store buffer: entry layout, byte-offset width and word-address helper.
package store_buffer_pkg;

    localparam int SB_XLEN   = 32;
    localparam int SB_AWIDTH = 32;
    localparam int SB_BYTES  = SB_XLEN / 8;
    localparam int BYTE_OFF  = $clog2(SB_XLEN / 8);

    typedef struct packed {
        logic [SB_AWIDTH-1:0] waddr;
        logic [SB_XLEN-1:0]   data;
        logic [SB_BYTES-1:0]  be;
    } sb_entry_t;

    function automatic logic [SB_AWIDTH-1:0] word_addr(input logic [SB_AWIDTH-1:0] a);
        return {a[SB_AWIDTH-1:BYTE_OFF], {BYTE_OFF{1'b0}}};
    endfunction

endpackage

// File: rtl/store_buffer.sv
// In-order store buffer between MEM stage and a single-port data memory, with load-hazard match.
// Define STORE_BUFFER_MERGE_EN to coalesce same-word pushes into the newest non-head entry.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int XLEN   = SB_XLEN,
    parameter int AWIDTH = SB_AWIDTH,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [AWIDTH-1:0] st_addr,
    input  logic [XLEN-1:0]   st_wdata,
    input  logic [XLEN/8-1:0] st_be,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              ld_valid,
    input  logic [AWIDTH-1:0] ld_addr,
    output logic              ld_hit,
    output logic              sb_empty
);

    localparam int BYTES = XLEN / 8;
    localparam int PW    = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

    sb_entry_t         ent [DEPTH];
    sb_entry_t         head;
    logic [PW-1:0]     rd_ptr, wr_ptr, last_ptr;
    logic [PW:0]       count;
    logic [AWIDTH-1:0] st_waddr, ld_waddr;
    logic              full, merge, accept, alloc, pop;
    logic [DEPTH-1:0]  hit_vec;

    assign st_waddr = word_addr(st_addr);
    assign ld_waddr = word_addr(ld_addr);
    assign last_ptr = wr_ptr - 1'b1;
    assign full     = (count == CNT_FULL);

`ifdef STORE_BUFFER_MERGE_EN
    sb_entry_t merged;

    // Never merge into the head: it may be on the bus this very cycle.
    assign merge = (count > CNT_ONE) && (ent[last_ptr].waddr == st_waddr);

    always_comb begin
        merged    = ent[last_ptr];
        merged.be = ent[last_ptr].be | st_be;
        for (int b = 0; b < BYTES; b++)
            if (st_be[b]) merged.data[8*b +: 8] = st_wdata[8*b +: 8];
    end
`else
    assign merge = 1'b0;
`endif

    // No full-cycle bypass: a same-cycle pop does not open st_ready.
    assign st_ready = !full || merge;
    assign accept   = st_valid && st_ready && (st_be != '0);
    assign alloc    = accept && !merge;
    assign mem_req  = (count != '0);
    assign pop      = mem_req && mem_gnt;
    assign sb_empty = !mem_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({alloc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity comes from rd_ptr/count.
    always_ff @(posedge clk) begin
        if (alloc)
            ent[wr_ptr] <= '{waddr: st_waddr, data: st_wdata, be: st_be};
`ifdef STORE_BUFFER_MERGE_EN
        else if (accept)
            ent[last_ptr] <= merged;
`endif
    end

    assign head      = ent[rd_ptr];
    assign mem_addr  = mem_req ? head.waddr : '0;
    assign mem_wdata = mem_req ? head.data  : '0;
    assign mem_be    = mem_req ? head.be    : '0;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ld
        logic [PW-1:0] off;
        assign off        = PW'(i) - rd_ptr;
        assign hit_vec[i] = ({1'b0, off} < count) && (ent[i].waddr == ld_waddr);
    end

    assign ld_hit = ld_valid && (|hit_vec);

endmodule
